// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
//
// Schedules one barrier plus an optional coin onto three lanes. It also counts
// down the remaining run distance and flags the end of a run.
//
// Flow: IDLE -> GAP (wait SPAWN_GAP frame ticks) -> SPAWN (pick lanes, one
// cycle) -> ACTIVE (wait until both objects are done) -> GAP ... and DONE once
// the distance runs out or lives are exhausted. Dropping i_run returns to IDLE
// from any state.
//
// Lane encoding: 00 none, 01 left, 10 mid, 11 right.
//
// Optional feature macro: SPAWN_FIXED_PATTERN_EN
//   When it is defined, the barrier lane comes from a rotating 01/10/11 counter
//   and the coin takes the following lane. The LFSR keeps running but does not
//   drive the lanes.
//
// Ports:
//   i_clk                  system clock
//   i_rst_n                synchronous active-low reset
//   i_frame_tick           one-cycle pulse per frame refresh
//   i_run                  game is in PLAY
//   i_zero_lives           lives exhausted
//   i_coin_done            coin left the screen or was collected
//   i_barrier_done         barrier left the screen
//   o_active_coin[1:0]     registered coin lane
//   o_active_barrier[1:0]  registered barrier lane
//   o_remaining_distance   registered metres left
//   o_finish               registered run-complete flag
// -----------------------------------------------------------------------------
module spawn_scheduler #(
    parameter logic [11:0] DIST_INIT        = 12'd999,
    parameter int          FRAMES_PER_METER = 8,
    parameter int          SPAWN_GAP        = 30,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_run,
    input  logic        i_zero_lives,
    input  logic        i_coin_done,
    input  logic        i_barrier_done,
    output logic [1:0]  o_active_coin,
    output logic [1:0]  o_active_barrier,
    output logic [11:0] o_remaining_distance,
    output logic        o_finish
);

    localparam int FW = (FRAMES_PER_METER > 1) ? $clog2(FRAMES_PER_METER) : 1;
    localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_METER - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(SPAWN_GAP);
    localparam logic [15:0]   LFSR_MASK  = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [15:0]   SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [1:0] LANE_NONE  = 2'b00;
    localparam logic [1:0] LANE_LEFT  = 2'b01;
    localparam logic [1:0] LANE_MID   = 2'b10;
    localparam logic [1:0] LANE_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SPAWN,
        ACTIVE,
        DONE
    } state_t;

    state_t        state, next_state;
    logic [GW-1:0] gap_cnt, next_gap;
    logic [FW-1:0] frame_cnt, next_frame;
    logic [11:0]   distance, next_dist;
    logic [1:0]    coin_q, next_coin;
    logic [1:0]    barrier_q, next_barrier;
    logic          finish_q, next_finish;
    logic [15:0]   lfsr, lfsr_next;
    logic [1:0]    spawn_barrier, spawn_coin;
    logic          running;
    logic          meter_wrap;
    logic          finish_cond;

    // Galois right-shift form: feedback is folded in wherever the mask has a 1.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

    assign running     = (state == GAP) || (state == SPAWN) || (state == ACTIVE);
    assign meter_wrap  = i_frame_tick && (frame_cnt == FRAME_LAST);
    // Running out of distance and losing the last life can both happen in one
    // cycle. They feed a single condition, so DONE is entered once.
    assign finish_cond = running && ((meter_wrap && (distance == 12'd1)) || i_zero_lives);

`ifdef SPAWN_FIXED_PATTERN_EN
    logic [1:0] rot_q;
    logic       spawn_taken;

    function automatic logic [1:0] lane_succ(input logic [1:0] lane);
        return (lane == LANE_RIGHT) ? LANE_LEFT : lane + 2'd1;
    endfunction

    assign spawn_barrier = rot_q;
    assign spawn_coin    = lane_succ(rot_q);
    assign spawn_taken   = i_run && !finish_cond && (state == SPAWN);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rot_q <= LANE_LEFT;
        end else if (spawn_taken) begin
            rot_q <= lane_succ(rot_q);
        end
    end
`else
    // Barrier must always occupy a lane. The coin is dropped rather than
    // stacked on top of the barrier.
    always_comb begin
        spawn_barrier = (lfsr[1:0] == LANE_NONE) ? LANE_MID : lfsr[1:0];
        spawn_coin    = (lfsr[3:2] == spawn_barrier) ? LANE_NONE : lfsr[3:2];
    end
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        next_state   = state;
        next_gap     = gap_cnt;
        next_frame   = frame_cnt;
        next_dist    = distance;
        next_coin    = coin_q;
        next_barrier = barrier_q;
        next_finish  = 1'b0;

        if (!i_run) begin
            next_state   = IDLE;
            next_coin    = LANE_NONE;
            next_barrier = LANE_NONE;
        end else begin
            if (running && i_frame_tick) begin
                if (meter_wrap) begin
                    next_frame = '0;
                    if (distance != 12'd0) begin
                        next_dist = distance - 12'd1;
                    end
                end else begin
                    next_frame = frame_cnt + FW'(1);
                end
            end

            if (finish_cond) begin
                next_state   = DONE;
                next_coin    = LANE_NONE;
                next_barrier = LANE_NONE;
                next_finish  = 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        next_state   = GAP;
                        next_dist    = DIST_INIT;
                        next_gap     = GAP_LOAD;
                        next_frame   = '0;
                        next_coin    = LANE_NONE;
                        next_barrier = LANE_NONE;
                    end
                    GAP: begin
                        if (i_frame_tick) begin
                            if (gap_cnt != '0) begin
                                next_gap = gap_cnt - GW'(1);
                            end
                            if (gap_cnt <= GW'(1)) begin
                                next_state = SPAWN;
                            end
                        end
                    end
                    SPAWN: begin
                        next_barrier = spawn_barrier;
                        next_coin    = spawn_coin;
                        next_state   = ACTIVE;
                    end
                    ACTIVE: begin
                        if (i_coin_done) begin
                            next_coin = LANE_NONE;
                        end
                        if (i_barrier_done) begin
                            next_barrier = LANE_NONE;
                        end
                        // Leave as soon as the last object clears. This avoids
                        // an idle cycle in ACTIVE with both lanes empty.
                        if ((next_coin == LANE_NONE) && (next_barrier == LANE_NONE)) begin
                            next_state = GAP;
                            next_gap   = GAP_LOAD;
                        end
                    end
                    DONE: begin
                        next_finish  = 1'b1;
                        next_coin    = LANE_NONE;
                        next_barrier = LANE_NONE;
                    end
                    default: begin
                        next_state = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this edge.
            state     <= IDLE;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            distance  <= DIST_INIT;
            coin_q    <= LANE_NONE;
            barrier_q <= LANE_NONE;
            finish_q  <= 1'b0;
            lfsr      <= SEED;
        end else begin
            state     <= next_state;
            gap_cnt   <= next_gap;
            frame_cnt <= next_frame;
            distance  <= next_dist;
            coin_q    <= next_coin;
            barrier_q <= next_barrier;
            finish_q  <= next_finish;
            lfsr      <= lfsr_next;
        end
    end

    assign o_active_coin        = coin_q;
    assign o_active_barrier     = barrier_q;
    assign o_remaining_distance = distance;
    assign o_finish             = finish_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
//
// Self-checking bench for spawn_scheduler. It uses DIST_INIT=3,
// FRAMES_PER_METER=2 and SPAWN_GAP=2.
//
// Expected lanes come from a reference model that works from the lane rules.
// With SPAWN_FIXED_PATTERN_EN, the model is a spawn index into the rotation
// 01, 10, 11. Otherwise it is a free-running copy of the 16-bit Galois LFSR,
// taken at the SPAWN cycle.
// -----------------------------------------------------------------------------
module tb_spawn_scheduler;

    localparam logic [11:0] DIST = 12'd3;
    localparam int          FPM  = 2;
    localparam int          GAPN = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        i_clk          = 1'b0;
    logic        i_rst_n        = 1'b0;
    logic        i_frame_tick   = 1'b0;
    logic        i_run          = 1'b0;
    logic        i_zero_lives   = 1'b0;
    logic        i_coin_done    = 1'b0;
    logic        i_barrier_done = 1'b0;
    logic [1:0]  o_active_coin;
    logic [1:0]  o_active_barrier;
    logic [11:0] o_remaining_distance;
    logic        o_finish;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: LFSR value now and one edge ago, and spawn count.
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;
    int          spawn_idx = 0;

    logic [16:0] obs;
    logic [16:0] e;
    assign obs = {o_active_coin, o_active_barrier, o_remaining_distance, o_finish};

    spawn_scheduler #(
        .DIST_INIT        (DIST),
        .FRAMES_PER_METER (FPM),
        .SPAWN_GAP        (GAPN),
        .LFSR_SEED        (SEED)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_frame_tick         (i_frame_tick),
        .i_run                (i_run),
        .i_zero_lives         (i_zero_lives),
        .i_coin_done          (i_coin_done),
        .i_barrier_done       (i_barrier_done),
        .o_active_coin        (o_active_coin),
        .o_active_barrier     (o_active_barrier),
        .o_remaining_distance (o_remaining_distance),
        .o_finish             (o_finish)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        m_lfsr_prev = m_lfsr;
        if (!i_rst_n) m_lfsr = SEED;
        else          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    function automatic logic [16:0] want(input logic [1:0] c, input logic [1:0] b,
                                         input int d, input logic f);
        return {c, b, 12'(d), f};
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Lanes the next spawn must show; call right after the edge that loads them.
    task automatic next_spawn(output logic [1:0] b, output logic [1:0] c);
`ifdef SPAWN_FIXED_PATTERN_EN
        b = 2'(spawn_idx % 3 + 1);
        c = 2'((spawn_idx + 1) % 3 + 1);
`else
        b = m_lfsr_prev[1:0];
        if (b == 2'b00) b = 2'b10;
        c = m_lfsr_prev[3:2];
        if (c == b) c = 2'b00;
`endif
        spawn_idx++;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_run = 1'b0; spawn_idx = 0;
        cyc(); cyc();
        e = want(0, 0, 3, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, e); end
        i_rst_n = 1'b1; i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL idle_hold: got %h want %h", obs, e); end
    endtask

    task automatic test_first_spawn();
        logic [1:0] b, c;
        i_run = 1'b1;
        cyc();
        e = want(0, 0, 3, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL run_start: got %h want %h", obs, e); end
        i_frame_tick = 1'b1;
        cyc();
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL gap_tick1: got %h want %h", obs, e); end
        cyc();
        e = want(0, 0, 2, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL gap_tick2: got %h want %h", obs, e); end
        i_frame_tick = 1'b0;
        cyc();
        next_spawn(b, c);
        e = want(c, b, 2, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL first_spawn: got %h want %h", obs, e); end
    endtask

    task automatic test_both_done();
        logic [1:0] b, c;
        i_coin_done = 1'b1; i_barrier_done = 1'b1;
        cyc();
        i_barrier_done = 1'b0;
        e = want(0, 0, 2, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL both_done: got %h want %h", obs, e); end
        // coin_done stays high in GAP and must be ignored.
        i_frame_tick = 1'b1;
        cyc();
        i_coin_done = 1'b0;
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL gap_reload_tick1: got %h want %h", obs, e); end
        cyc();
        e = want(0, 0, 1, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL gap_reload_tick2: got %h want %h", obs, e); end
        i_frame_tick = 1'b0;
        cyc();
        next_spawn(b, c);
        e = want(c, b, 1, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL second_spawn: got %h want %h", obs, e); end
        i_barrier_done = 1'b1;
        cyc();
        i_barrier_done = 1'b0;
        e = want(c, 0, 1, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL barrier_only_done: got %h want %h", obs, e); end
        i_coin_done = 1'b1;
        cyc();
        i_coin_done = 1'b0;
        e = want(0, 0, 1, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL coin_only_done: got %h want %h", obs, e); end
    endtask

    // Six ticks from a fresh run; optionally lose the last life on the final tick.
    task automatic test_run_to_finish(input bit lives_on_last);
        logic [1:0] eb, ec;
        eb = 2'b00; ec = 2'b00;
        i_run = 1'b0;
        cyc();
        n_tests++;
        if ({o_active_coin, o_active_barrier, o_finish} !== 5'b0) begin
            n_fail++; $display("FAIL idle_outputs: got %b want 00000", {o_active_coin, o_active_barrier, o_finish});
        end
        i_run = 1'b1;
        cyc();
        e = want(0, 0, 3, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reload_dist: got %h want %h", obs, e); end
        for (int k = 1; k <= 5; k++) begin
            i_frame_tick = 1'b1;
            cyc();
            i_frame_tick = 1'b0;
            e = want(ec, eb, 3 - k / 2, 0); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL dist_tick%0d: got %h want %h", k, obs, e); end
            cyc();
            if (k == 2) begin
                next_spawn(eb, ec);
                e = want(ec, eb, 2, 0); n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL run_spawn: got %h want %h", obs, e); end
            end
        end
        i_frame_tick = 1'b1; i_zero_lives = lives_on_last;
        cyc();
        i_frame_tick = 1'b0;
        e = want(0, 0, 0, 1); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL finish_tick6 lives=%0d: got %h want %h", lives_on_last, obs, e); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL done_persist%0d: got %h want %h", k, obs, e); end
        end
        i_zero_lives = 1'b0; i_run = 1'b0;
        cyc();
        n_tests++;
        if ({o_active_coin, o_active_barrier, o_finish} !== 5'b0) begin
            n_fail++; $display("FAIL done_to_idle: got %b want 00000", {o_active_coin, o_active_barrier, o_finish});
        end
    endtask

    task automatic test_zero_lives_early();
        i_run = 1'b1;
        cyc();
        i_zero_lives = 1'b1;
        cyc();
        i_zero_lives = 1'b0;
        e = want(0, 0, 3, 1); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL lives_in_gap: got %h want %h", obs, e); end
        cyc();
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL lives_done_hold: got %h want %h", obs, e); end
        i_run = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_active();
        logic [1:0] b, c;
        for (int r = 0; r < 2; r++) begin
            i_run = 1'b1;
            if (r == 1) i_rst_n = 1'b1;
            cyc();
            e = want(0, 0, 3, 0); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_spawn%0d: got %h want %h", r, obs, e); end
            i_frame_tick = 1'b1;
            cyc(); cyc();
            i_frame_tick = 1'b0;
            cyc();
            next_spawn(b, c);
            e = want(c, b, 2, 0); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL spawn_round%0d: got %h want %h", r, obs, e); end
            if (r == 0) begin
                i_rst_n = 1'b0; spawn_idx = 0;
                cyc();
                e = want(0, 0, 3, 0); n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL reset_mid_active: got %h want %h", obs, e); end
            end
        end
        i_zero_lives = 1'b1;
        cyc();
        i_zero_lives = 1'b0;
        e = want(0, 0, 2, 1); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL enter_done: got %h want %h", obs, e); end
        i_rst_n = 1'b0; spawn_idx = 0;
        cyc();
        e = want(0, 0, 3, 0); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_mid_done: got %h want %h", obs, e); end
        i_rst_n = 1'b1; i_run = 1'b0;
        cyc();
    endtask

    task automatic test_random_spawns();
        logic [1:0] b, c, prev_b;
        int spawns, cycles;
        spawns = 0; cycles = 0;
        prev_b = o_active_barrier;
        while (spawns < 1000 && cycles < 50000) begin
            i_frame_tick   = ($urandom_range(0, 1) == 0);
            i_coin_done    = ($urandom_range(0, 1) == 0);
            i_barrier_done = ($urandom_range(0, 1) == 0);
            i_zero_lives   = ($urandom_range(0, 199) == 0);
            if (o_finish)    i_run = 1'b0;
            else if (!i_run) i_run = 1'b1;
            else             i_run = ($urandom_range(0, 99) != 0);
            cyc();
            cycles++;
            if (prev_b == 2'b00 && o_active_barrier != 2'b00) begin
                next_spawn(b, c);
                spawns++;
                n_tests++;
                if ({o_active_coin, o_active_barrier} !== {c, b}) begin
                    n_fail++;
                    $display("FAIL rand_spawn%0d: got coin=%b bar=%b want coin=%b bar=%b",
                             spawns, o_active_coin, o_active_barrier, c, b);
                end
                n_tests++;
                if (o_active_coin == o_active_barrier) begin
                    n_fail++; $display("FAIL rand_overlap%0d: coin=%b bar=%b", spawns, o_active_coin, o_active_barrier);
                end
            end
            prev_b = o_active_barrier;
        end
        n_tests++;
        if (spawns < 1000) begin n_fail++; $display("FAIL spawn_budget: got %0d want 1000", spawns); end
        i_frame_tick = 1'b0; i_coin_done = 1'b0; i_barrier_done = 1'b0;
        i_zero_lives = 1'b0; i_run = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_both_done();
        test_run_to_finish(1'b0);
        test_run_to_finish(1'b1);
        test_zero_lives_early();
        test_reset_mid_active();
        test_random_spawns();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIST_INIT, 12'd999, starting remaining distance in metres.
- FRAMES_PER_METER, 8, frame ticks per metre decrement.
- SPAWN_GAP, 30, frame ticks between end of one spawn and the next.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, reset, synchronous active-low.
- i_frame_tick, in, 1, one-cycle pulse per frame refresh.
- i_run, in, 1, game is in PLAY.
- i_zero_lives, in, 1, lives exhausted.
- i_coin_done, in, 1, coin has left the screen or been collected.
- i_barrier_done, in, 1, barrier has left the screen.
- o_active_coin, out, 2, coin lane.
- o_active_barrier, out, 2, barrier lane.
- o_remaining_distance, out, 12, metres left.
- o_finish, out, 1, run complete.

REQ-003 Lane encoding SHALL be: 00 none, 01 left, 10 mid, 11 right.

REQ-004 Clock and reset SHALL be one clock (i_clk) with reset i_rst_n, synchronous and active-low.

Function
REQ-005 The FSM states SHALL be IDLE, GAP, SPAWN, ACTIVE and DONE.

REQ-006 Transition priority SHALL be: reset > i_run=0 (to IDLE) > finish condition (to DONE) > normal transitions.

REQ-007 In IDLE, both lane outputs SHALL be 00 and o_finish 0; on i_run=1 the block SHALL load distance=DIST_INIT, gap counter=SPAWN_GAP and frame counter=0, then go to GAP.

REQ-008 In GAP, each i_frame_tick SHALL decrement the gap counter; the tick that takes it to 0 SHALL move the FSM to SPAWN on the next cycle.

REQ-009 SPAWN SHALL last exactly one cycle:
- barrier lane = lfsr[1:0], with 00 mapped to 10.
- coin lane = lfsr[3:2], forced to 00 if it equals the barrier lane.
- Both lanes SHALL be registered to the outputs on entry to ACTIVE.

REQ-010 In ACTIVE:
- i_coin_done SHALL clear o_active_coin to 00.
- i_barrier_done SHALL clear o_active_barrier to 00.
- Both may occur in the same cycle.
- When both outputs are 00, the block SHALL reload the gap counter to SPAWN_GAP and go to GAP.

REQ-011 Done pulses received outside ACTIVE SHALL be ignored.

REQ-012 In GAP, SPAWN and ACTIVE, the frame counter SHALL count i_frame_tick. On reaching FRAMES_PER_METER it SHALL wrap to 0 and decrement o_remaining_distance, saturating at 0.

REQ-013 The finish condition SHALL be: the distance decrement reaching 0, or i_zero_lives=1. Both in the same cycle SHALL give a single entry to DONE.

REQ-014 In DONE:
- o_finish=1, lanes 00, distance held.
- DONE SHALL persist until i_run=0, then go to IDLE.

REQ-015 The LFSR SHALL be a 16-bit Galois LFSR, mask 16'hB400, advancing every cycle out of reset; it SHALL never hold 0.

REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-017 When i_rst_n=0 at a rising i_clk edge, the block SHALL set:
- state=IDLE.
- o_active_coin=00, o_active_barrier=00.
- o_remaining_distance=DIST_INIT, o_finish=0.
- gap counter=0, frame counter=0.
- lfsr=LFSR_SEED.

REQ-018 Reset asserted mid-spawn or mid-DONE SHALL apply REQ-017 at the next edge, with no residual pulses.

Configuration
REQ-019 With SPAWN_FIXED_PATTERN_EN defined:
- SPAWN SHALL take the barrier lane from a 2-bit rotating counter (01, 10, 11, 01, ...), advanced once per SPAWN and reset to 01.
- The coin lane SHALL be the next value in that rotation.
- The LFSR SHALL still exist but not drive lanes.

REQ-020 Without SPAWN_FIXED_PATTERN_EN, lanes SHALL come from the LFSR per REQ-009.

Verification
REQ-021 The bench (DIST_INIT=3, FRAMES_PER_METER=2, SPAWN_GAP=2) SHALL cover these scenarios:
- Pattern build, i_run=1, 2 ticks -> SPAWN, then o_active_barrier=01, o_active_coin=10.
- i_coin_done and i_barrier_done in the same ACTIVE cycle -> both 00 next cycle, GAP reloaded to 2; next spawn gives barrier 10, coin 11.
- i_run=1 with no done pulses, 6 ticks -> distance 3,2,1,0; o_finish=1 one cycle after the 6th tick; lanes 00.
- i_zero_lives=1 coincident with the tick that takes distance to 0 -> single DONE entry; o_finish stays 1 until i_run=0, then IDLE with lanes 00.
- i_rst_n=0 for one edge during ACTIVE -> next cycle all outputs at reset values, o_remaining_distance=3.
- LFSR build, 1000 spawns -> barrier never 00, and coin never equals barrier.
